edge_event_arbiter: RTL
=======================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of monitored event inputs (2..16).
REQ-002 Parameter CH_W, default 2, channel-index width, equal to clog2(NUM_CH).
REQ-003 I_clk  input  1  sole clock; all logic on rising edge.
REQ-004 I_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 I_sig  input  NUM_CH  monitored signals, synchronous to I_clk.
REQ-006 I_chEn  input  NUM_CH  per-channel enable mask.
REQ-007 I_evtRdy  input  1  downstream ready for the granted event.
REQ-008 O_evtVld  output  1  event grant valid.
REQ-009 O_evtCh  output  CH_W  index of the granted channel, stable while O_evtVld=1.
REQ-010 O_pend  output  NUM_CH  pending-event vector.
REQ-011 O_busy  output  1  high when FSM not in IDLE.
REQ-012 I_ovflClr  input  1  clears overflow flags (used only with macro, see REQ-030).
REQ-013 O_ovfl  output  NUM_CH  sticky per-channel overflow flags.

Function
REQ-014 Each channel SHALL register I_sig[i] into lst[i] every cycle; a falling edge is I_sig[i]=0 with lst[i]=1.
REQ-015 A detected falling edge on an enabled channel SHALL set pend[i] at the same clock edge, visible on O_pend the next cycle.
REQ-016 Edges on channels with I_chEn[i]=0 SHALL be ignored; deasserting I_chEn[i] SHALL clear pend[i] the next edge unless channel i is currently granted.
REQ-017 FSM states: IDLE, GRANT; IDLE->GRANT when any pend bit set, GRANT->IDLE on O_evtVld & I_evtRdy.
REQ-018 On IDLE->GRANT the arbiter SHALL select the first set pend bit at or after rrPtr, searching upward with wraparound from NUM_CH-1 to 0, and register it into O_evtCh.
REQ-019 O_evtVld SHALL equal (state==GRANT); latency from the I_sig sampling edge to O_evtVld high is 2 cycles when idle.
REQ-020 O_evtVld SHALL stay high and O_evtCh stable until I_evtRdy=1; no grant is withdrawn.
REQ-021 On handshake, pend[O_evtCh] SHALL clear and rrPtr SHALL become O_evtCh+1, wrapping to 0 after NUM_CH-1.
REQ-022 A new edge on the granted channel in the handshake cycle SHALL leave pend set (set wins over clear).
REQ-023 After a handshake the FSM SHALL spend one cycle in IDLE, so throughput is one event per 2 cycles maximum.
REQ-024 Simultaneous edges on several channels SHALL all be latched and granted in round-robin order.
REQ-025 O_busy SHALL equal (state!=IDLE).

Reset
REQ-026 I_rst_n=0 SHALL asynchronously set lst=0, pend=0, rrPtr=0, state=IDLE, O_evtVld=0, O_evtCh=0, O_ovfl=0.
REQ-027 A reset asserted mid-grant SHALL drop O_evtVld immediately and discard all pending events.
REQ-028 In the first cycle after reset release, lst=0, so no falling edge is detected.

Configuration
REQ-029 The macro EDGE_EVT_OVERFLOW_EN SHALL gate overflow tracking.
REQ-030 With EDGE_EVT_OVERFLOW_EN defined, an enabled-channel edge while pend[i]=1 and not cleared in that cycle SHALL set O_ovfl[i]; I_ovflClr=1 clears all flags, and a same-cycle set wins.
REQ-031 Without EDGE_EVT_OVERFLOW_EN, O_ovfl SHALL be constant 0, I_ovflClr SHALL be ignored, and no overflow logic is synthesized.

Verification
REQ-032 Single event: ch1 1->0, I_evtRdy=1 -> O_evtVld high 2 cycles after sampling for 1 cycle, O_evtCh=1, O_pend=0 afterward.
REQ-033 Simultaneous edges: ch0, ch2, ch3 fall in the same cycle, rrPtr=0, I_evtRdy=1 -> grants ch0, ch2, ch3 in that order, 2 cycles apart.
REQ-034 Backpressure: I_evtRdy=0 for 10 cycles while ch2 granted -> O_evtVld=1 and O_evtCh=2 held all 10 cycles; a ch1 edge meanwhile is granted next.
REQ-035 Mask: I_chEn=4'b1011, ch2 falls -> no pend[2], no grant; clearing I_chEn[0] with pend[0]=1 and not granted -> pend[0]=0 the next cycle.
REQ-036 Overflow (macro defined): two ch3 edges before grant -> O_ovfl[3]=1 until I_ovflClr; macro undefined -> O_ovfl=0.
REQ-037 Async reset: I_rst_n low mid-grant, off the clock edge -> O_evtVld=0 and O_pend=0 immediately, no grant after release.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Falling-edge event detector with a round-robin grant and a valid/ready handshake.
// Optional sticky per-channel overflow tracking is compiled in with EDGE_EVT_OVERFLOW_EN.
module edge_event_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic [NUM_CH-1:0] I_sig,
    input  logic [NUM_CH-1:0] I_chEn,
    input  logic              I_evtRdy,
    output logic              O_evtVld,
    output logic [CH_W-1:0]   O_evtCh,
    output logic [NUM_CH-1:0] O_pend,
    output logic              O_busy,
    input  logic              I_ovflClr,
    output logic [NUM_CH-1:0] O_ovfl
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] lst;
    logic [NUM_CH-1:0] pend;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   evt_ch;

    logic              handshake_c;
    logic [NUM_CH-1:0] set_c;
    logic [NUM_CH-1:0] clr_c;
    logic [NUM_CH-1:0] granted_c;
    logic [NUM_CH-1:0] pend_nxt_c;
    logic [NUM_CH-1:0] elig_c;
    logic              hi_found_c;
    logic              lo_found_c;
    logic [CH_W-1:0]   hi_ch_c;
    logic [CH_W-1:0]   lo_ch_c;
    logic [CH_W-1:0]   sel_ch_c;
    logic [CH_W-1:0]   rr_nxt_c;

    assign handshake_c = (state == GRANT) && I_evtRdy;

    // Pending update: a new edge wins over handshake or mask clear in the same cycle.
    always_comb begin
        set_c     = lst & ~I_sig & I_chEn;
        clr_c     = '0;
        granted_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            granted_c[i] = (state == GRANT) && (evt_ch == CH_W'(i));
            clr_c[i]     = (handshake_c && granted_c[i]) || (!I_chEn[i] && !granted_c[i]);
        end
        pend_nxt_c = set_c | (pend & ~clr_c);
    end

    // Round-robin pick: lowest eligible index at/after rr_ptr, else lowest overall (wrap).
    always_comb begin
        elig_c     = pend & I_chEn;
        hi_found_c = 1'b0;
        lo_found_c = 1'b0;
        hi_ch_c    = '0;
        lo_ch_c    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (elig_c[i] && (CH_W'(i) >= rr_ptr) && !hi_found_c) begin
                hi_found_c = 1'b1;
                hi_ch_c    = CH_W'(i);
            end
            if (elig_c[i] && !lo_found_c) begin
                lo_found_c = 1'b1;
                lo_ch_c    = CH_W'(i);
            end
        end
        sel_ch_c = hi_found_c ? hi_ch_c : lo_ch_c;
        rr_nxt_c = (evt_ch == CH_W'(NUM_CH - 1)) ? '0 : evt_ch + CH_W'(1);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state  <= IDLE;
            lst    <= '0;
            pend   <= '0;
            rr_ptr <= '0;
            evt_ch <= '0;
        end else begin
            lst  <= I_sig;
            pend <= pend_nxt_c;
            case (state)
                IDLE: begin
                    if (lo_found_c) begin
                        state  <= GRANT;
                        evt_ch <= sel_ch_c;
                    end
                end
                GRANT: begin
                    if (I_evtRdy) begin
                        state  <= IDLE;
                        rr_ptr <= rr_nxt_c;
                    end
                end
            endcase
        end
    end

    assign O_evtVld = (state == GRANT);
    assign O_busy   = (state != IDLE);
    assign O_evtCh  = evt_ch;
    assign O_pend   = pend;

`ifdef EDGE_EVT_OVERFLOW_EN
    logic [NUM_CH-1:0] ovfl;

    // An edge landing on a still-pending, not-being-cleared channel is an overflow.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            ovfl <= '0;
        end else begin
            ovfl <= (set_c & pend & ~clr_c) | (ovfl & ~{NUM_CH{I_ovflClr}});
        end
    end

    assign O_ovfl = ovfl;
`else
    logic unused_ovfl_clr;
    assign unused_ovfl_clr = I_ovflClr;
    assign O_ovfl          = '0;
`endif

endmodule
